// File: rtl/mpmc10_app_cmd_gen.sv
// MIG app command issuer: walks a start address through cnt commands; first app_en 1 cycle after ISSUE entry, then one per cycle.
// Backpressure: app_en/app_cmd/app_addr hold while app_rdy is low; writes wait for data credit, reads for an outstanding slot.
module mpmc10_app_cmd_gen #(
  parameter int         AWID       = 29,
  parameter int         CNTW       = 6,
  parameter int         ADDR_INC   = 8,
  parameter int         MAX_RD_OUT = 16,
  parameter logic [2:0] CMD_READ   = 3'b001,
  parameter logic [2:0] CMD_WRITE  = 3'b000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req,
  input  logic            we,
  input  logic [AWID-1:0] adr,
  input  logic [CNTW-1:0] cnt,
  input  logic            app_rdy,
  input  logic            wdf_beat,
  input  logic            rd_beat,
  output logic            app_en,
  output logic [2:0]      app_cmd,
  output logic [AWID-1:0] app_addr,
  output logic            busy,
  output logic            done,
  output logic [CNTW:0]   rd_out,
  output logic            err
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  localparam logic [CNTW:0]   MAX_RD = (CNTW+1)'(MAX_RD_OUT);
  localparam logic [AWID-1:0] A_INC  = AWID'(ADDR_INC);

  state_t          state_q, state_d;
  logic            we_q, we_d;
  logic [CNTW-1:0] rem_q, rem_d;
  logic [CNTW:0]   credit_q, credit_d;
  logic [CNTW:0]   rd_out_q, rd_out_d;
  logic            app_en_q, app_en_d;
  logic [2:0]      app_cmd_q, app_cmd_d;
  logic [AWID-1:0] app_addr_q, app_addr_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic accept, wr_acc, rd_acc, rd_ret, eligible, continuing;

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    rem_d      = rem_q;
    credit_d   = credit_q;
    rd_out_d   = rd_out_q;
    app_en_d   = app_en_q;
    app_cmd_d  = app_cmd_q;
    app_addr_d = app_addr_q;
    err_d      = err_q;
    continuing = 1'b1;

    accept = app_en_q & app_rdy;
    wr_acc = accept & we_q;
    rd_acc = accept & ~we_q;

    // Write credit saturates at all-ones; an overflowing beat is flagged.
    if (wdf_beat && !wr_acc) begin
      if (credit_q == '1) err_d = 1'b1;
      else                credit_d = credit_q + 1'b1;
    end else if (!wdf_beat && wr_acc) begin
      credit_d = credit_q - 1'b1;
    end

    // A returned read with nothing outstanding is dropped and flagged.
    rd_ret = rd_beat & (rd_out_q != '0);
    if (rd_beat && rd_out_q == '0) err_d = 1'b1;
    if (rd_acc && !rd_ret)      rd_out_d = rd_out_q + 1'b1;
    else if (!rd_acc && rd_ret) rd_out_d = rd_out_q - 1'b1;

    eligible = we_q ? (credit_d != '0) : (rd_out_d < MAX_RD);

    case (state_q)
      IDLE: begin
        app_en_d  = 1'b0;
        app_cmd_d = CMD_WRITE;
        if (req) begin
          we_d       = we;
          app_addr_d = adr;
          rem_d      = cnt;
          if (cnt == '0) begin
            state_d = DONE;
          end else begin
            state_d   = ISSUE;
            app_cmd_d = we ? CMD_WRITE : CMD_READ;
          end
        end
      end
      ISSUE: begin
        if (accept) begin
          app_addr_d = app_addr_q + A_INC;
          rem_d      = rem_q - 1'b1;
          if (rem_q == CNTW'(1)) begin
            continuing = 1'b0;
            state_d    = DONE;
          end
        end
        app_en_d = continuing & eligible;
      end
      DONE: begin
        app_en_d  = 1'b0;
        app_cmd_d = CMD_WRITE;
        state_d   = IDLE;
      end
      default: begin
        app_en_d = 1'b0;
        state_d  = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      rem_q      <= '0;
      credit_q   <= '0;
      rd_out_q   <= '0;
      app_en_q   <= 1'b0;
      app_cmd_q  <= CMD_WRITE;
      app_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      rem_q      <= rem_d;
      credit_q   <= credit_d;
      rd_out_q   <= rd_out_d;
      app_en_q   <= app_en_d;
      app_cmd_q  <= app_cmd_d;
      app_addr_q <= app_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign app_en   = app_en_q;
  assign app_cmd  = app_cmd_q;
  assign app_addr = app_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_out   = rd_out_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mpmc10_app_cmd_gen.sv
// Bench for mpmc10_app_cmd_gen: directed scenarios then random traffic, every cycle compared to a transfer-level model.
module tb_mpmc10_app_cmd_gen;

  localparam int AWID  = 29;
  localparam int CNTW  = 6;
  localparam int MAXRD = 16;
  localparam int MAXCR = 127;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req = 1'b0;
  logic            we = 1'b0;
  logic [AWID-1:0] adr = '0;
  logic [CNTW-1:0] cnt = '0;
  logic            app_rdy = 1'b0;
  logic            wdf_beat = 1'b0;
  logic            rd_beat = 1'b0;
  logic            app_en;
  logic [2:0]      app_cmd;
  logic [AWID-1:0] app_addr;
  logic            busy;
  logic            done;
  logic [CNTW:0]   rd_out;
  logic            err;

  mpmc10_app_cmd_gen #(
    .AWID(AWID), .CNTW(CNTW), .ADDR_INC(8), .MAX_RD_OUT(MAXRD),
    .CMD_READ(3'b001), .CMD_WRITE(3'b000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .adr(adr), .cnt(cnt),
    .app_rdy(app_rdy), .wdf_beat(wdf_beat), .rd_beat(rd_beat),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .busy(busy),
    .done(done), .rd_out(rd_out), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: transfer progress, resources and expected pins.
  bit              m_act = 0, m_fin = 0, m_en = 0, m_we = 0, m_err = 0;
  int              m_left = 0, m_credit = 0, m_rdout = 0, m_acc = 0;
  logic [AWID-1:0] m_addr = '0;
  logic [2:0]      m_cmd = 3'b000;

  int              dut_acc = 0, dut_done = 0;
  logic [AWID-1:0] dut_last_addr = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_fin = 0; m_en = 0; m_we = 0; m_err = 0;
    m_left = 0; m_credit = 0; m_rdout = 0;
    m_addr = '0; m_cmd = 3'b000;
  endtask

  task automatic step();
    bit acc;
    int rb;
    int nc;
    if (app_en === 1'b1 && app_rdy) begin
      dut_acc++;
      dut_last_addr = app_addr;
    end
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      acc = m_en && app_rdy;
      if (acc) m_acc++;
      nc = m_credit + int'(wdf_beat) - int'(acc && m_we);
      if (nc > MAXCR) begin nc = MAXCR; m_err = 1; end
      m_credit = nc;
      rb = int'(rd_beat);
      if (rd_beat && m_rdout == 0) begin m_err = 1; rb = 0; end
      m_rdout = m_rdout + int'(acc && !m_we) - rb;
      if (m_fin) begin
        m_fin = 0;
        m_cmd = 3'b000;
      end else if (m_act) begin
        if (acc) begin
          m_addr = m_addr + 29'd8;
          m_left--;
        end
        if (m_left == 0) begin
          m_act = 0; m_fin = 1; m_en = 0;
        end else begin
          m_en = m_we ? (m_credit > 0) : (m_rdout < MAXRD);
        end
      end else if (req) begin
        m_we = we; m_addr = adr; m_left = int'(cnt); m_en = 0;
        if (cnt == 0) m_fin = 1;
        else begin m_act = 1; m_cmd = we ? 3'b000 : 3'b001; end
      end
    end
    @(negedge clk);
    if (done === 1'b1) dut_done++;
    chk("app_en", 32'(app_en), 32'(m_en));
    chk("app_cmd", 32'(app_cmd), 32'(m_cmd));
    chk("app_addr", 32'(app_addr), 32'(m_addr));
    chk("busy", 32'(busy), 32'(m_act | m_fin));
    chk("done", 32'(done), 32'(m_fin));
    chk("rd_out", 32'(rd_out), 32'(m_rdout));
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic issue(input logic w, input logic [AWID-1:0] a, input logic [CNTW-1:0] c);
    req = 1'b1; we = w; adr = a; cnt = c;
    step();
    req = 1'b0;
  endtask

  task automatic run_idle(input int bound);
    int i;
    i = 0;
    while ((m_act || m_fin) && i < bound) begin
      step();
      i++;
    end
    chk("idle_timeout", 32'(m_act | m_fin), 32'd0);
  endtask

  task automatic drain_rd();
    int i;
    i = 0;
    rd_beat = 1'b1;
    while (m_rdout > 0 && i < 40) begin
      step();
      i++;
    end
    rd_beat = 1'b0;
    chk("drain_rd", 32'(rd_out), 32'd0);
  endtask

  initial begin
    int a0, d0;
    @(negedge clk);
    // Reset state
    repeat (2) step();
    chk("rst_app_cmd", 32'(app_cmd), 32'd0);
    rst_n = 1'b1;
    app_rdy = 1'b1;
    step();

    // Read burst of 4 at 0x100
    a0 = dut_acc; d0 = dut_done;
    issue(1'b0, 29'h100, 6'd4);
    run_idle(20);
    chk("t1_accepts", 32'(dut_acc - a0), 32'd4);
    chk("t1_last_addr", 32'(dut_last_addr), 32'h118);
    chk("t1_done", 32'(dut_done - d0), 32'd1);
    chk("t1_rd_out", 32'(rd_out), 32'd4);
    drain_rd();

    // Write of 3 paced by late data credit
    a0 = dut_acc; d0 = dut_done;
    issue(1'b1, 29'h200, 6'd3);
    for (int i = 0; i < 20; i++) begin
      wdf_beat = (i == 5 || i == 9 || i == 13);
      step();
    end
    wdf_beat = 1'b0;
    chk("t2_accepts", 32'(dut_acc - a0), 32'd3);
    chk("t2_done", 32'(dut_done - d0), 32'd1);

    // Read of 20 against outstanding-read limit
    a0 = dut_acc; d0 = dut_done;
    issue(1'b0, 29'h1000, 6'd20);
    repeat (30) step();
    chk("t3_stall_rd_out", 32'(rd_out), 32'd16);
    chk("t3_stall_acc", 32'(dut_acc - a0), 32'd16);
    rd_beat = 1'b1; step(); rd_beat = 1'b0;
    repeat (5) step();
    chk("t3_one_more", 32'(dut_acc - a0), 32'd17);
    for (int k = 0; k < 12 && (m_act || m_fin); k++) begin
      rd_beat = 1'b1; step(); rd_beat = 1'b0;
      step(); step();
    end
    run_idle(20);
    chk("t3_accepts", 32'(dut_acc - a0), 32'd20);
    chk("t3_done", 32'(dut_done - d0), 32'd1);
    drain_rd();

    // app_rdy stall mid-transfer, then address wrap
    a0 = dut_acc;
    issue(1'b0, 29'h2000, 6'd4);
    step(); step();
    app_rdy = 1'b0;
    repeat (5) step();
    app_rdy = 1'b1;
    run_idle(20);
    chk("t4_accepts", 32'(dut_acc - a0), 32'd4);
    issue(1'b0, 29'h1FFF_FFF8, 6'd2);
    run_idle(20);
    chk("t4_wrap_addr", 32'(dut_last_addr), 32'd0);
    drain_rd();

    // Zero-count request, req while busy, spurious read return
    d0 = dut_done;
    issue(1'b0, 29'h40, 6'd0);
    chk("t5_cnt0_done", 32'(dut_done - d0), 32'd1);
    step();
    a0 = dut_acc;
    issue(1'b0, 29'h300, 6'd2);
    req = 1'b1; we = 1'b1; adr = 29'h999; cnt = 6'd5;
    step(); step();
    req = 1'b0;
    run_idle(20);
    chk("t5_busy_req_ignored", 32'(dut_acc - a0), 32'd2);
    drain_rd();
    rd_beat = 1'b1; step(); rd_beat = 1'b0;
    chk("t5_err_set", 32'(err), 32'd1);
    repeat (5) step();
    chk("t5_err_sticky", 32'(err), 32'd1);

    // Reset after 2 of 5 write accepts
    wdf_beat = 1'b1; repeat (5) step(); wdf_beat = 1'b0;
    a0 = dut_acc;
    issue(1'b1, 29'h500, 6'd5);
    for (int i = 0; i < 20 && (dut_acc - a0) < 2; i++) step();
    rst_n = 1'b0;
    step();
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_cmd", 32'(app_cmd), 32'd0);
    chk("t6_rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    step();
    a0 = dut_acc;
    issue(1'b0, 29'h600, 6'd3);
    run_idle(20);
    chk("t6_after_rst", 32'(dut_acc - a0), 32'd3);
    drain_rd();

    // Write credit saturation
    wdf_beat = 1'b1;
    repeat (MAXCR) step();
    chk("t7_no_sat_err", 32'(err), 32'd0);
    step();
    chk("t7_sat_err", 32'(err), 32'd1);
    wdf_beat = 1'b0;

    // Random traffic
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    a0 = dut_acc;
    m_acc = 0;
    for (int i = 0; i < 1500; i++) begin
      req      = ($urandom_range(0, 7) == 0);
      we       = 1'($urandom);
      adr      = 29'($urandom);
      cnt      = 6'($urandom_range(0, 12));
      app_rdy  = ($urandom_range(0, 3) != 0);
      wdf_beat = ($urandom_range(0, 2) == 0);
      rd_beat  = ($urandom_range(0, 2) == 0);
      step();
    end
    req = 1'b0; wdf_beat = 1'b1; rd_beat = 1'b1; app_rdy = 1'b1;
    run_idle(200);
    wdf_beat = 1'b0; rd_beat = 1'b0;
    chk("rand_accepts", 32'(dut_acc - a0), 32'(m_acc));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
